// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_D        = 32;
  localparam int NREG_D        = 32;
  localparam int LINK_OFFSET_D = 4;

  function automatic logic [XLEN_D-1:0] link_value(
    input logic [XLEN_D-1:0] pc,
    input logic [XLEN_D-1:0] off
  );
    return pc + off;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits with issue/writeback priority.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_rd_i,
  output logic [NREG-1:0] busy_o,
  output logic [AW:0]     cnt_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  // A new producer owns the register, so set beats clear.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (issue_valid_i && issue_rd_i == AW'(i))
        busy_d[i] = 1'b1;
      else if (wb_valid_i && wb_rd_i == AW'(i))
        busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 1; i < NREG; i++)
      cnt_d = cnt_d + (AW+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with scoreboard, writeback bypass
// and link-address writeback.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN        = XLEN_D,
  parameter int NREG        = NREG_D,
  parameter int AW          = $clog2(NREG),
  parameter int LINK_OFFSET = LINK_OFFSET_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_link,
  input  logic [XLEN-1:0] wb_pc,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] link_val;
  logic [XLEN-1:0] wval;
  logic [NREG-1:0] busy;
  logic            hit1, hit2;

  if (XLEN == XLEN_D) begin : g_link_fn
    assign link_val = link_value(wb_pc, XLEN_D'(LINK_OFFSET));
  end else begin : g_link_add
    assign link_val = wb_pc + XLEN'(LINK_OFFSET);
  end

  assign wval = wb_link ? link_val : wb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (wb_valid && wb_rd != '0) begin
      regs_q[wb_rd] <= wval;
    end
  end

  assign hit1 = wb_valid && wb_rd == rs1_addr;
  assign hit2 = wb_valid && wb_rd == rs2_addr;

  always_comb begin
    rd1_data = '0;
    if (rs1_addr != '0)
      rd1_data = hit1 ? wval : regs_q[rs1_addr];
  end

  always_comb begin
    rd2_data = '0;
    if (rs2_addr != '0)
      rd2_data = hit2 ? wval : regs_q[rs2_addr];
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .busy_o        (busy),
    .cnt_o         (pending_cnt)
  );

  // A register being written back is readable via bypass, so not busy.
  assign rs1_busy = busy[rs1_addr] && !hit1 && rs1_addr != '0;
  assign rs2_busy = busy[rs2_addr] && !hit2 && rs2_addr != '0;
  assign rd_busy  = busy[issue_rd] && issue_rd != '0;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a behavioural
// register/scoreboard model compared every cycle.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rd1_data, rd2_data;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_link;
  logic [31:0] wb_pc;
  logic [5:0]  pending_cnt;

  int errors = 0;
  int checks = 0;

  regfile_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd1_data    (rd1_data),
    .rd2_data    (rd2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_link     (wb_link),
    .wb_pc       (wb_pc),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Architectural model: plain arrays updated by the rules.
  logic [31:0] m_reg [32];
  bit          m_busy [32];

  function automatic logic [31:0] m_wval();
    return wb_link ? wb_pc + 32'd4 : wb_data;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_valid && wb_rd == a) return m_wval();
    return m_reg[a];
  endfunction

  function automatic logic m_rbusy(input logic [4:0] a);
    return a != 0 && m_busy[a] && !(wb_valid && wb_rd == a);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 0;
        m_busy[i] = 0;
      end
    end else begin
      if (wb_valid && wb_rd != 0) begin
        m_reg[wb_rd]  = m_wval();
        m_busy[wb_rd] = 0;
      end
      if (issue_valid && issue_rd != 0)
        m_busy[issue_rd] = 1;
    end
  end

  always @(negedge clk) begin
    check("m_rd1", rd1_data, m_read(rs1_addr));
    check("m_rd2", rd2_data, m_read(rs2_addr));
    check("m_rs1b", 32'(rs1_busy), 32'(m_rbusy(rs1_addr)));
    check("m_rs2b", 32'(rs2_busy), 32'(m_rbusy(rs2_addr)));
    check("m_rdb", 32'(rd_busy),
          32'(issue_rd != 0 && m_busy[issue_rd]));
    check("m_cnt", 32'(pending_cnt), 32'(m_count()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 0;
    wb_valid    = 0;
    wb_link     = 0;
  endtask

  initial begin
    rst_n = 0;
    rs1_addr = 0; rs2_addr = 0;
    issue_valid = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    wb_link = 0; wb_pc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset state
    rs1_addr = 5; rs2_addr = 0;
    @(negedge clk);
    check("rst_rd1", rd1_data, 32'h0);
    check("rst_rd2", rd2_data, 32'h0);
    check("rst_cnt", 32'(pending_cnt), 32'd0);
    check("rst_busy", 32'({rs1_busy, rs2_busy, rd_busy}), 32'd0);

    // write + bypass
    tick();
    wb_valid = 1; wb_rd = 7; wb_data = 32'hDEADBEEF; rs1_addr = 7;
    @(negedge clk);
    check("bypass", rd1_data, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("stored", rd1_data, 32'hDEADBEEF);

    // register 0
    tick();
    wb_valid = 1; wb_rd = 0; wb_data = 32'h1234;
    issue_valid = 1; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    @(negedge clk);
    check("x0_rd1", rd1_data, 32'h0);
    check("x0_rd2", rd2_data, 32'h0);
    tick();
    @(negedge clk);
    check("x0_cnt", 32'(pending_cnt), 32'd0);

    // link writes with wrap
    tick();
    wb_valid = 1; wb_link = 1; wb_pc = 32'hFFFFFFFE;
    wb_rd = 1; wb_data = 32'h55;
    tick();
    rs1_addr = 1;
    @(negedge clk);
    check("link_wrap", rd1_data, 32'h00000002);
    tick();
    wb_valid = 1; wb_link = 1; wb_pc = 32'h100; wb_rd = 1;
    tick();
    @(negedge clk);
    check("link_100", rd1_data, 32'h00000104);

    // scoreboard set / clear
    tick();
    issue_valid = 1; issue_rd = 3;
    tick();
    rs1_addr = 3; issue_rd = 3;
    @(negedge clk);
    check("sb_rs1b", 32'(rs1_busy), 32'd1);
    check("sb_rdb", 32'(rd_busy), 32'd1);
    check("sb_cnt1", 32'(pending_cnt), 32'd1);
    tick();
    wb_valid = 1; wb_rd = 3; wb_data = 32'hAA;
    @(negedge clk);
    check("sb_wb_rs1b", 32'(rs1_busy), 32'd0);
    check("sb_wb_rd1", rd1_data, 32'hAA);
    tick();
    @(negedge clk);
    check("sb_clr_rdb", 32'(rd_busy), 32'd0);
    check("sb_cnt0", 32'(pending_cnt), 32'd0);

    // simultaneous set and clear on r9
    tick();
    issue_valid = 1; issue_rd = 9;
    wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
    tick();
    rs1_addr = 9; rs2_addr = 9; issue_rd = 9;
    @(negedge clk);
    check("sim_rs1b", 32'(rs1_busy), 32'd1);
    check("sim_rdb", 32'(rd_busy), 32'd1);
    check("sim_rd1", rd1_data, 32'h99);
    check("sim_cnt", 32'(pending_cnt), 32'd1);

    // more producers, then writeback to an idle register
    tick();
    issue_valid = 1; issue_rd = 4;
    tick();
    issue_valid = 1; issue_rd = 5;
    tick();
    wb_valid = 1; wb_rd = 12; wb_data = 32'hC0FFEE;
    tick();
    rs2_addr = 12; issue_rd = 12;
    @(negedge clk);
    check("idle_rd2", rd2_data, 32'hC0FFEE);
    check("idle_rdb", 32'(rd_busy), 32'd0);
    check("cnt3", 32'(pending_cnt), 32'd3);

    // asynchronous reset mid-cycle
    tick();
    issue_rd = 9; rs1_addr = 9;
    #2 rst_n = 0;
    #1;
    check("arst_cnt", 32'(pending_cnt), 32'd0);
    check("arst_rs1b", 32'(rs1_busy), 32'd0);
    check("arst_rdb", 32'(rd_busy), 32'd0);
    check("arst_rd1", rd1_data, 32'h0);
    check("arst_rd2", rd2_data, 32'h0);
    tick();
    rst_n = 1;

    // table-driven mix checked by the model
    for (int k = 0; k < 40; k++) begin
      issue_valid = (k % 3) != 0;
      issue_rd    = 5'((k * 7) % 32);
      wb_valid    = (k % 2) == 1;
      wb_rd       = 5'((k * 5 + 3) % 32);
      wb_data     = 32'h1000_0000 + 32'(k) * 32'h0101;
      wb_link     = (k % 5) == 0;
      wb_pc       = 32'hFFFF_FFF0 + 32'(k) * 32'd4;
      rs1_addr    = 5'((k * 5 + 3) % 32);
      rs2_addr    = 5'((k * 7 + 7) % 32);
      @(posedge clk);
      #1;
    end
    issue_valid = 0; wb_valid = 0; wb_link = 0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the RV32 core.
- Adds a per-register scoreboard (pending-write tracking), same-cycle write-to-read bypass, a link-address writeback mode, and asynchronous reset of all architectural state.
- Sits between decode (read/issue side) and writeback.
- Decode uses the busy flags to stall on RAW and WAW hazards.

Parameters:
- XLEN, 32: data width of each register.
- NREG, 32: number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(NREG): register address width (derived).
- LINK_OFFSET, 4: value added to wb_pc when a link write is performed.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset; one clock, asynchronous, active-low.
- rs1_addr, input, AW: read port 1 address.
- rs2_addr, input, AW: read port 2 address.
- rd1_data, output, XLEN: read port 1 data (combinational).
- rd2_data, output, XLEN: read port 2 data (combinational).
- rs1_busy, output, 1: register at rs1_addr has an outstanding write not being resolved this cycle.
- rs2_busy, output, 1: same, for rs2_addr.
- rd_busy, output, 1: register at issue_rd is pending (WAW indicator).
- issue_valid, input, 1: an instruction writing issue_rd is issuing this cycle.
- issue_rd, input, AW: destination of the issuing instruction.
- wb_valid, input, 1: writeback this cycle.
- wb_rd, input, AW: writeback destination.
- wb_data, input, XLEN: writeback data.
- wb_link, input, 1: when 1, the write value is wb_pc + LINK_OFFSET instead of wb_data.
- wb_pc, input, XLEN: PC of the writing instruction.
- pending_cnt, output, AW+1: number of registers currently marked busy.

Behaviour:
- Reset (rst_n low, asynchronous): all registers cleared to 0, all busy bits cleared, pending_cnt = 0.
  - While in reset, read outputs reflect zeroed storage.
  - Reset mid-operation discards all pending state.
- Write value:
  - wval = wb_link ? (wb_pc + LINK_OFFSET) : wb_data.
  - Addition is modulo 2^XLEN; wrap from all-ones is silent.
- Write: on posedge clk, when wb_valid and wb_rd != 0, register[wb_rd] <= wval.
- Register 0:
  - Reads as 0 on both ports.
  - Never written.
  - Never busy; issue_rd == 0 and wb_rd == 0 have no scoreboard effect.
- Reads (combinational, zero latency):
  - Address 0 gives 0.
  - Otherwise, if wb_valid and wb_rd == addr, the port returns wval (bypass).
  - Otherwise the port returns stored register[addr].
  - Both ports may address the same register.
- Scoreboard, per register i != 0, updated on posedge clk:
  - set = issue_valid && issue_rd == i
  - clr = wb_valid && wb_rd == i
  - busy[i] next = set ? 1 : (clr ? 0 : busy[i]).
  - Simultaneous set and clear on the same register: set wins (new producer owns the register).
  - Set on an already-busy register is legal; the bit stays 1.
  - No counting of multiple producers; decode must stall on rd_busy.
- Busy outputs:
  - rsN_busy = busy[rsN_addr] && !(wb_valid && wb_rd == rsN_addr) && rsN_addr != 0.
  - A register being written this cycle is therefore not busy, because its data is bypassed.
  - rd_busy = busy[issue_rd] && issue_rd != 0; it is independent of issue_valid.
- pending_cnt:
  - Registered population count of the busy bits.
  - Reflects the state after the most recent edge.
  - Maximum value NREG-1.
- Writeback to a non-busy register is legal: data is written and busy stays 0.

Decomposition:
- Package regfile_pkg:
  - Default constants XLEN_D = 32, NREG_D = 32, LINK_OFFSET_D = 4.
  - Function computing the link value.
- Sub-module regfile_scoreboard (parameter NREG):
  - Contains the busy vector, the set/clear priority logic and the popcount register.
  - Exposes the busy vector to the parent.
- Storage array, bypass muxes and write-value selection stay in regfile_sb.

Test Plan:
1. Reset then read:
   - Stimulus: rst_n low 2 cycles, release; rs1_addr = 5, rs2_addr = 0.
   - Required: rd1_data = 0, rd2_data = 0, pending_cnt = 0, all busy = 0.
2. Write then read, and bypass:
   - Stimulus: wb_valid = 1, wb_rd = 7, wb_data = 0xDEADBEEF, rs1_addr = 7.
   - Required: rd1_data = 0xDEADBEEF in the same cycle.
   - After the edge, with wb_valid = 0: still 0xDEADBEEF.
3. Register 0 write:
   - Stimulus: wb_valid = 1, wb_rd = 0, wb_data = 0x1234; issue_valid = 1, issue_rd = 0.
   - Required: reads of address 0 return 0; pending_cnt stays 0.
4. Link write with wrap:
   - Stimulus: wb_link = 1, wb_pc = 0xFFFFFFFE, wb_rd = 1.
   - Required: register 1 = 0x00000002.
   - Second case: wb_pc = 0x100 gives 0x104.
5. Scoreboard set/clear:
   - Stimulus: issue rd = 3.
   - Required next cycle: rs1_busy = 1 at rs1_addr = 3, rd_busy = 1 at issue_rd = 3, pending_cnt = 1.
   - Stimulus: wb rd = 3 with rs1_addr = 3.
   - Required: rs1_busy = 0 that cycle; busy cleared after the edge; pending_cnt = 0.
6. Simultaneous issue and writeback to register 9:
   - Required: after the edge, busy[9] = 1 and register 9 holds the written data.
   - Stimulus: assert rst_n low asynchronously mid-cycle.
   - Required: all busy bits and registers become 0 immediately.
